// File: rtl/dg_tri_pkg.sv
// rtl/dg_tri_pkg.sv - shared types and width helper for the tristate bus arbiter
package dg_tri_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_TURN = 2'd2
   } arb_state_e;

   // Bits needed to hold values 0..value-1, never less than one so that
   // degenerate parameter choices still give legal vector widths.
   function automatic int clog2_min1(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/dg_tri_bus_arbiter_if.sv
// rtl/dg_tri_bus_arbiter_if.sv - requester/bus signal bundle for the tristate bus arbiter
interface dg_tri_bus_arbiter_if #(
   parameter int WIDTH    = 1,
   parameter int CHANNELS = 2
);
   logic [CHANNELS-1:0]       req;
   logic [CHANNELS*WIDTH-1:0] data;
   logic [CHANNELS-1:0]       grant;
   logic [WIDTH-1:0]          bus_y;
   logic                      bus_oe;
   logic                      bus_oe_n;

   modport slave (
      input  req,
      input  data,
      output grant,
      output bus_y,
      output bus_oe,
      output bus_oe_n
   );

   modport master (
      output req,
      output data,
      input  grant,
      input  bus_y,
      input  bus_oe,
      input  bus_oe_n
   );
endinterface

// File: rtl/dg_rr_pick.sv
// rtl/dg_rr_pick.sv - combinational round-robin picker searching upward from pointer+1
module dg_rr_pick #(
   parameter int CHANNELS = 2,
   parameter int PTR_W    = 1
) (
   input  logic [CHANNELS-1:0] req_i,
   input  logic [PTR_W-1:0]    ptr_i,
   output logic [CHANNELS-1:0] winner_o,
   output logic [PTR_W-1:0]    winner_idx_o,
   output logic                valid_o
);

   // Two passes: channels above the pointer first, then wrap to 0..pointer,
   // so the last winner is always the lowest-priority candidate.
   always_comb begin
      winner_o     = '0;
      winner_idx_o = '0;
      valid_o      = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (!valid_o && req_i[c] && (c > int'(ptr_i))) begin
            winner_o[c]  = 1'b1;
            winner_idx_o = PTR_W'(c);
            valid_o      = 1'b1;
         end
      end
      for (int c = 0; c < CHANNELS; c++) begin
         if (!valid_o && req_i[c] && (c <= int'(ptr_i))) begin
            winner_o[c]  = 1'b1;
            winner_idx_o = PTR_W'(c);
            valid_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dg_tri_bus_arbiter.sv
// rtl/dg_tri_bus_arbiter.sv - round-robin arbiter driving one shared tristate bus
module dg_tri_bus_arbiter
   import dg_tri_pkg::*;
#(
   parameter int WIDTH      = 1,
   parameter int CHANNELS   = 2,
   parameter int TURNAROUND = 1,
   parameter int MAX_HOLD   = 0,
   parameter int KEEPER     = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   dg_tri_bus_arbiter_if.slave  bus
);

   localparam int PTR_W  = clog2_min1(CHANNELS);
   localparam int HOLD_W = clog2_min1(MAX_HOLD + 1);

   localparam logic [PTR_W-1:0]  PTR_RESET = PTR_W'(CHANNELS - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
   localparam logic [3:0]        TURN_LOAD = 4'((TURNAROUND == 0) ? 0 : TURNAROUND - 1);

   arb_state_e          state_q, state_d;
   logic [CHANNELS-1:0] grant_q, grant_d;
   logic                oe_q, oe_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [3:0]          turn_q, turn_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [WIDTH-1:0]    keep_q, keep_d;

   logic [CHANNELS-1:0] pick_onehot;
   logic [PTR_W-1:0]    pick_idx;
   logic                pick_valid;
   logic [WIDTH-1:0]    owner_data;
   logic                owner_req;
   logic                release_own;
   logic                arb_now;

   dg_rr_pick #(
      .CHANNELS (CHANNELS),
      .PTR_W    (PTR_W)
   ) u_pick (
      .req_i        (bus.req),
      .ptr_i        (ptr_q),
      .winner_o     (pick_onehot),
      .winner_idx_o (pick_idx),
      .valid_o      (pick_valid)
   );

   // The pointer always names the current (or most recent) owner.
   assign owner_data  = bus.data[int'(ptr_q)*WIDTH +: WIDTH];
   assign owner_req   = bus.req[ptr_q];
   assign release_own = !owner_req || ((MAX_HOLD != 0) && (hold_q == HOLD_LAST));

   // Next-state and registered-output logic for IDLE / OWN / TURN.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      oe_d    = oe_q;
      hold_d  = hold_q;
      turn_d  = turn_q;
      ptr_d   = ptr_q;
      keep_d  = keep_q;
      arb_now = 1'b0;

      case (state_q)
         ST_IDLE: arb_now = 1'b1;
         ST_OWN: begin
            keep_d = owner_data;
            if (release_own) begin
               grant_d = '0;
               oe_d    = 1'b0;
               if (TURNAROUND == 0) begin
                  arb_now = 1'b1;
               end else begin
                  state_d = ST_TURN;
                  turn_d  = TURN_LOAD;
               end
            end else if (hold_q != '1) begin
               hold_d = hold_q + 1'b1;
            end
         end
         ST_TURN: begin
            if (turn_q == 4'd0) begin
               arb_now = 1'b1;
            end else begin
               turn_d = turn_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Arbitration point: a winner takes the bus on this edge, otherwise rest.
      if (arb_now) begin
         if (pick_valid) begin
            state_d = ST_OWN;
            grant_d = pick_onehot;
            oe_d    = 1'b1;
            ptr_d   = pick_idx;
            hold_d  = '0;
         end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            oe_d    = 1'b0;
         end
      end
   end

   // State and output flops; reset drops ownership without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         oe_q    <= 1'b0;
         hold_q  <= '0;
         turn_q  <= '0;
         ptr_q   <= PTR_RESET;
         keep_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         oe_q    <= oe_d;
         hold_q  <= hold_d;
         turn_q  <= turn_d;
         ptr_q   <= ptr_d;
         keep_q  <= keep_d;
      end
   end

   assign bus.grant    = grant_q;
   assign bus.bus_oe   = oe_q;
   assign bus.bus_oe_n = ~oe_q;
   assign bus.bus_y    = oe_q ? owner_data : ((KEEPER != 0) ? keep_q : {WIDTH{1'bz}});

endmodule

// File: tb/tb_dg_tri_bus_arbiter.sv
// tb/tb_dg_tri_bus_arbiter.sv - scoreboard bench for the tristate bus arbiter
module tb_dg_tri_bus_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   typedef struct {
      logic [3:0] grant;
      logic       oe;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   dg_tri_bus_arbiter_if #(.WIDTH(8), .CHANNELS(2)) if_a ();
   dg_tri_bus_arbiter_if #(.WIDTH(8), .CHANNELS(2)) if_b ();
   dg_tri_bus_arbiter_if #(.WIDTH(8), .CHANNELS(2)) if_c ();
   dg_tri_bus_arbiter_if #(.WIDTH(8), .CHANNELS(4)) if_d ();

   dg_tri_bus_arbiter #(.WIDTH(8), .CHANNELS(2), .TURNAROUND(1), .MAX_HOLD(3), .KEEPER(0))
      u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
   dg_tri_bus_arbiter #(.WIDTH(8), .CHANNELS(2), .TURNAROUND(0), .MAX_HOLD(0), .KEEPER(0))
      u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
   dg_tri_bus_arbiter #(.WIDTH(8), .CHANNELS(2), .TURNAROUND(2), .MAX_HOLD(0), .KEEPER(1))
      u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
   dg_tri_bus_arbiter #(.WIDTH(8), .CHANNELS(4), .TURNAROUND(1), .MAX_HOLD(1), .KEEPER(0))
      u_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

   function automatic bit released8(input logic [7:0] v);
      return (v === 8'hzz) || (v === 8'h00);
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      if_a.req = '0; if_b.req = '0; if_c.req = '0; if_d.req = '0;
      if_a.data = '0; if_b.data = '0; if_c.data = '0; if_d.data = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (if_a.grant !== 2'b00 || if_a.bus_oe !== 1'b0 || if_a.bus_oe_n !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_a: got grant=%b oe=%b oe_n=%b, expected 00 0 1", if_a.grant, if_a.bus_oe, if_a.bus_oe_n);
      end
      n_checks++;
      if (if_d.grant !== 4'b0000 || if_d.bus_oe !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_d: got grant=%b oe=%b, expected 0000 0", if_d.grant, if_d.bus_oe);
      end
      n_checks++;
      if (if_c.bus_y !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_keeper: got bus_y=%h, expected 00", if_c.bus_y);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_max_hold();
      logic [3:0] exp_g [13];
      exp_t e;
      exp_g = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
      for (int i = 0; i <= 13; i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if ({2'b00, if_a.grant} !== e.grant || if_a.bus_oe !== e.oe) begin
               n_fail++;
               $display("FAIL max_hold cycle %0d: got grant=%b oe=%b, expected grant=%b oe=%b",
                        i, if_a.grant, if_a.bus_oe, e.grant[1:0], e.oe);
            end
         end
         if (i <= 12) begin
            if_a.req = (i < 11) ? 2'b11 : 2'b00;
            sb_q.push_back('{exp_g[i], exp_g[i] != 4'h0});
         end
      end
   endtask

   task automatic test_basic();
      exp_t e;
      @(negedge clk);
      if_a.data = {8'h11, 8'h3C};
      if_a.req  = 2'b01;
      sb_q.push_back('{4'h1, 1'b1});
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if ({2'b00, if_a.grant} !== e.grant || if_a.bus_oe !== e.oe || if_a.bus_y !== 8'h3C) begin
         n_fail++;
         $display("FAIL basic_grant: got grant=%b oe=%b bus_y=%h, expected 01 1 3c", if_a.grant, if_a.bus_oe, if_a.bus_y);
      end
      if_a.data[7:0] = 8'h5A;
      #1;
      n_checks++;
      if (if_a.bus_y !== 8'h5A) begin
         n_fail++;
         $display("FAIL basic_passthrough: got bus_y=%h, expected 5a", if_a.bus_y);
      end
      if_a.req = 2'b00;
      sb_q.push_back('{4'h0, 1'b0});
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if ({2'b00, if_a.grant} !== e.grant || if_a.bus_oe_n !== 1'b1 || !released8(if_a.bus_y)) begin
         n_fail++;
         $display("FAIL basic_release: got grant=%b oe_n=%b bus_y=%h, expected 00 1 zz", if_a.grant, if_a.bus_oe_n, if_a.bus_y);
      end
      sb_q.push_back('{4'h0, 1'b0});
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if ({2'b00, if_a.grant} !== e.grant || if_a.bus_oe !== e.oe) begin
         n_fail++;
         $display("FAIL basic_idle: got grant=%b oe=%b, expected 00 0", if_a.grant, if_a.bus_oe);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] req_seq [3];
      logic [7:0] bus_seq [3];
      exp_t       e;
      req_seq = '{2'b11, 2'b10, 2'b00};
      bus_seq = '{8'h3C, 8'hC3, 8'h00};
      if_b.data = {8'hC3, 8'h3C};
      sb_q.push_back('{4'h1, 1'b1});
      sb_q.push_back('{4'h2, 1'b1});
      sb_q.push_back('{4'h0, 1'b0});
      for (int i = 0; i <= 3; i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if ({2'b00, if_b.grant} !== e.grant || if_b.bus_oe !== e.oe || if_b.bus_oe_n !== ~e.oe) begin
               n_fail++;
               $display("FAIL b2b_grant cycle %0d: got grant=%b oe=%b oe_n=%b, expected grant=%b oe=%b",
                        i, if_b.grant, if_b.bus_oe, if_b.bus_oe_n, e.grant[1:0], e.oe);
            end
            n_checks++;
            if (e.oe ? (if_b.bus_y !== bus_seq[i-1]) : !released8(if_b.bus_y)) begin
               n_fail++;
               $display("FAIL b2b_bus cycle %0d: got bus_y=%h, expected %h", i, if_b.bus_y, bus_seq[i-1]);
            end
         end
         if (i < 3) if_b.req = req_seq[i];
      end
   endtask

   task automatic test_keeper();
      logic [1:0] req_seq [7];
      logic [3:0] exp_g   [7];
      logic [7:0] bus_seq [7];
      exp_t       e;
      req_seq = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
      exp_g   = '{4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0};
      bus_seq = '{8'hA5, 8'hA5, 8'hA5, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
      if_c.data = {8'h3C, 8'hA5};
      for (int i = 0; i <= 7; i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if ({2'b00, if_c.grant} !== e.grant || if_c.bus_oe !== e.oe || if_c.bus_y !== bus_seq[i-1]) begin
               n_fail++;
               $display("FAIL keeper cycle %0d: got grant=%b oe=%b bus_y=%h, expected grant=%b oe=%b bus_y=%h",
                        i, if_c.grant, if_c.bus_oe, if_c.bus_y, e.grant[1:0], e.oe, bus_seq[i-1]);
            end
         end
         if (i == 2) if_c.data[7:0] = 8'h00;
         if (i < 7) begin
            if_c.req = req_seq[i];
            sb_q.push_back('{exp_g[i], exp_g[i] != 4'h0});
         end
      end
      n_checks++;
      if (if_a.bus_oe_n !== 1'b1 || !released8(if_a.bus_y)) begin
         n_fail++;
         $display("FAIL no_keeper_idle: got oe_n=%b bus_y=%h, expected 1 zz", if_a.bus_oe_n, if_a.bus_y);
      end
   endtask

   task automatic test_rotate();
      logic [3:0] exp_g [11];
      exp_t e;
      exp_g = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h0};
      for (int i = 0; i <= 11; i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if (if_d.grant !== e.grant || if_d.bus_oe !== e.oe) begin
               n_fail++;
               $display("FAIL rotate cycle %0d: got grant=%b oe=%b, expected grant=%b oe=%b",
                        i, if_d.grant, if_d.bus_oe, e.grant, e.oe);
            end
         end
         if (i <= 10) begin
            if_d.req = (i < 9) ? 4'b1111 : 4'b0000;
            sb_q.push_back('{exp_g[i], exp_g[i] != 4'h0});
         end
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      @(negedge clk);
      if_a.req = 2'b10;
      sb_q.push_back('{4'h2, 1'b1});
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if ({2'b00, if_a.grant} !== e.grant || if_a.bus_oe !== e.oe || if_a.bus_y !== 8'h11) begin
         n_fail++;
         $display("FAIL areset_own: got grant=%b oe=%b bus_y=%h, expected 10 1 11", if_a.grant, if_a.bus_oe, if_a.bus_y);
      end
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if (if_a.grant !== 2'b00 || if_a.bus_oe !== 1'b0 || if_a.bus_oe_n !== 1'b1 || !released8(if_a.bus_y)) begin
         n_fail++;
         $display("FAIL areset_clear: got grant=%b oe=%b oe_n=%b bus_y=%h, expected 00 0 1 zz",
                  if_a.grant, if_a.bus_oe, if_a.bus_oe_n, if_a.bus_y);
      end
      n_checks++;
      if (if_c.bus_y !== 8'h00) begin
         n_fail++;
         $display("FAIL areset_keeper: got bus_y=%h, expected 00", if_c.bus_y);
      end
      #1 rst_n = 1'b1;
      if_a.req = 2'b11;
      sb_q.push_back('{4'h1, 1'b1});
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if ({2'b00, if_a.grant} !== e.grant || if_a.bus_oe !== e.oe) begin
         n_fail++;
         $display("FAIL areset_first_winner: got grant=%b oe=%b, expected 01 1", if_a.grant, if_a.bus_oe);
      end
      if_a.req = 2'b00;
      sb_q.push_back('{4'h0, 1'b0});
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if ({2'b00, if_a.grant} !== e.grant || if_a.bus_oe !== e.oe) begin
         n_fail++;
         $display("FAIL areset_release: got grant=%b oe=%b, expected 00 0", if_a.grant, if_a.bus_oe);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_max_hold();
      test_basic();
      test_back_to_back();
      test_keeper();
      test_rotate();
      test_async_reset();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
